// File: rtl/sram_arb_pkg.sv
// Shared constants and response-tracker encoding for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_CNT_W   = 4;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_t;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating count of consecutive cycles a pending fetch has lost arbitration.
module sram_arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic req,
  input  logic gnt,
  output logic starve
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  logic [STARVE_CNT_W-1:0] cnt;
  logic [STARVE_CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = '0;
    if (req && !gnt) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + STARVE_CNT_W'(1);
    end
  end

  // starve mirrors cnt==CNT_MAX but is kept as its own flop for a clean grant path
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      starve <= (cnt_next == CNT_MAX);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and load/store requesters onto one synchronous SRAM port.
// Define SRAM_ARB_STARVE_EN to add the fetch anti-starvation counter.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  resp_t resp;
  resp_t resp_next;
  logic  starve;

`ifdef SRAM_ARB_STARVE_EN
  sram_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .resetn (resetn),
    .req    (i_req),
    .gnt    (i_gnt),
    .starve (starve)
  );
`else
  logic [STARVE_CNT_W-1:0] starve_max_unused;
  assign starve_max_unused = STARVE_CNT_W'(STARVE_MAX);
  assign starve            = 1'b0;
`endif

  // Grant selection and response-tracker next state
  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    resp_next = RESP_NONE;
    if (resetn) begin
      if (i_req && (!d_req || starve)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
    if (i_gnt) begin
      resp_next = RESP_INST;
    end else if (d_gnt && (d_wen == '0)) begin
      resp_next = RESP_DATA;
    end
  end

  // SRAM command follows the winner in the grant cycle
  always_comb begin
    sram_en    = i_gnt | d_gnt;
    sram_wen   = d_gnt ? d_wen : '0;
    sram_addr  = d_gnt ? d_addr : i_addr;
    sram_wdata = d_gnt ? d_wdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp <= RESP_NONE;
    end else begin
      resp <= resp_next;
    end
  end

  // rvalid is masked while reset is held so an in-flight read is dropped
  assign i_rvalid = resetn && (resp == RESP_INST);
  assign d_rvalid = resetn && (resp == RESP_DATA);
  assign i_rdata  = sram_rdata;
  assign d_rdata  = sram_rdata;

endmodule
